// File: rtl/pll_reset_sequencer_pkg.sv
// pll_rst_pkg: sequencer state encoding and reset-cause codes shared by the sequencer and its bench
package pll_rst_pkg;
  typedef enum logic [2:0] {S_HOLD, S_STABLE, S_PERIPH, S_RUN, S_SWRST} state_t;
  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock/sw-request inputs and staged reset outputs; master drives inputs, slave is the sequencer
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       periph_rst_n;
  logic       cpu_rst_n;
  logic [1:0] rst_cause;
  logic       seq_busy;
  modport master (output pll_locked, sw_rst_req, input periph_rst_n, cpu_rst_n, rst_cause, seq_busy);
  modport slave  (input pll_locked, sw_rst_req, output periph_rst_n, cpu_rst_n, rst_cause, seq_busy);
endinterface

// File: rtl/pll_reset_sequencer_bit_sync.sv
// bit_sync: STAGES-deep synchronizer (clk, async active-low rst_n clears chain, d async in, q synced out)
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  end
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: filters PLL lock and releases periph then cpu resets (clk, async rst_n, bus: pll_locked/sw_rst_req in, periph_rst_n/cpu_rst_n/rst_cause/seq_busy out)
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CPU_DELAY_CYCLES   = 16,
  parameter int SW_RST_CYCLES      = 64,
  parameter int CNT_W              = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pll_reset_sequencer_if.slave   bus
);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);
  logic             locked_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_q, periph_d;
  logic             cpu_q, cpu_d;
  logic             busy_q;
  logic [1:0]       cause_q, cause_d;
  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    periph_d = periph_q;
    cpu_d    = cpu_q;
    cause_d  = cause_q;
    if (!locked_s && state_q inside {S_PERIPH, S_RUN, S_SWRST}) begin
      state_d  = S_HOLD;
      cnt_d    = '0;
      periph_d = 1'b0;
      cpu_d    = 1'b0;
      cause_d  = CAUSE_LOCK;
    end else begin
      case (state_q)
        S_HOLD: begin
          cnt_d    = '0;
          periph_d = 1'b0;
          cpu_d    = 1'b0;
          state_d  = locked_s ? S_STABLE : S_HOLD;
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d  = S_PERIPH;
            cnt_d    = '0;
            periph_d = 1'b1;
          end
        end
        S_PERIPH: begin
          if (cnt_q == CPU_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            cpu_d   = 1'b1;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (bus.sw_rst_req) begin
            state_d  = S_SWRST;
            periph_d = 1'b0;
            cpu_d    = 1'b0;
            cause_d  = CAUSE_SW;
          end
        end
        S_SWRST: begin
          if (cnt_q == SW_LAST) begin
            state_d  = S_PERIPH;
            cnt_d    = '0;
            periph_d = 1'b1;
          end
        end
        default: begin
          state_d  = S_HOLD;
          cnt_d    = '0;
          periph_d = 1'b0;
          cpu_d    = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      busy_q   <= 1'b1;
      cause_q  <= CAUSE_EXT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      busy_q   <= !cpu_d;
      cause_q  <= cause_d;
    end
  end
  assign bus.periph_rst_n = periph_q;
  assign bus.cpu_rst_n    = cpu_q;
  assign bus.seq_busy     = busy_q;
  assign bus.rst_cause    = cause_q;
endmodule
